ysyx_23060332_ifu: RTL and testbench



---
 rtl/ysyx_23060332_ifu.sv | 110 +++++++++++
 tb/tb_ysyx_23060332_ifu.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time,
// buffers the returned word for decode and squashes fetches on redirect.
module ysyx_23060332_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            req_valid_q, req_valid_d;
  logic            inst_valid_q, inst_valid_d;
  logic [XLEN-1:0] rpc;

  assign rpc = redirect_pc & ~(XLEN'(3));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          // old address already accepted: its response must be dropped
          kill_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_valid) begin
      pc_d = rpc;
    end
    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Testbench for ysyx_23060332_ifu: directed scenarios plus a randomized
// run checked against a fetch-stream reference model.
module tb_ysyx_23060332_ifu;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  ysyx_23060332_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  // leaves time at a falling edge with rst_n just released
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== BASE) begin
      errors++;
      $display("FAIL reset_req: got v=%b a=%h want v=1 a=%h",
               imem_req_valid, imem_req_addr, BASE);
    end
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_inst: got v=%b i=%h pc=%h want 0 0 0",
               inst_valid, inst, inst_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_req: got %b want 1", imem_req_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      a = BASE + 32'(4 * (c / 3));
      checks++;
      if (imem_req_valid !== (c % 3 == 0) || inst_valid !== (c % 3 == 2)) begin
        errors++;
        $display("FAIL stream_valid c=%0d: got req=%b iv=%b want req=%b iv=%b",
                 c, imem_req_valid, inst_valid, c % 3 == 0, c % 3 == 2);
      end
      if (c % 3 == 0) begin
        checks++;
        if (imem_req_addr !== a) begin
          errors++;
          $display("FAIL stream_addr c=%0d: got %h want %h", c, imem_req_addr, a);
        end
      end
      if (c % 3 == 2) begin
        checks++;
        if (inst_pc !== a || inst !== memfn(a)) begin
          errors++;
          $display("FAIL stream_inst c=%0d: got pc=%h i=%h want pc=%h i=%h",
                   c, inst_pc, inst, a, memfn(a));
        end
      end
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      imem_rsp_valid = (c % 3 == 1);
      imem_rsp_data  = memfn(a);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_slow_mem();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c <= 4) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== BASE) begin
          errors++;
          $display("FAIL slow_req c=%0d: got v=%b a=%h want v=1 a=%h",
                   c, imem_req_valid, imem_req_addr, BASE);
        end
      end else begin
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== BASE) begin
          errors++;
          $display("FAIL slow_noreq c=%0d: got v=%b a=%h want v=0 a=%h",
                   c, imem_req_valid, imem_req_addr, BASE);
        end
      end
      checks++;
      if (inst_valid !== (c >= 10)) begin
        errors++;
        $display("FAIL slow_iv c=%0d: got %b want %b", c, inst_valid, c >= 10);
      end
      if (c >= 10) begin
        checks++;
        if (inst !== memfn(BASE) || inst_pc !== BASE) begin
          errors++;
          $display("FAIL slow_inst c=%0d: got i=%h pc=%h want i=%h pc=%h",
                   c, inst, inst_pc, memfn(BASE), BASE);
        end
      end
      imem_req_ready = (c == 4);
      imem_rsp_valid = (c == 9);
      imem_rsp_data  = (c == 9) ? memfn(BASE) : 32'hdead_beef;
      inst_ready     = 1'b0;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c >= 2 && c <= 8) begin
        checks++;
        if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0 ||
            inst !== memfn(BASE) || inst_pc !== BASE) begin
          errors++;
          $display("FAIL bp_hold c=%0d: got iv=%b rv=%b i=%h pc=%h want 1 0 %h %h",
                   c, inst_valid, imem_req_valid, inst, inst_pc, memfn(BASE), BASE);
        end
      end
      if (c == 9) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== BASE + 32'h4 ||
            inst_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_next: got rv=%b a=%h iv=%b want 1 %h 0",
                   imem_req_valid, imem_req_addr, inst_valid, BASE + 32'h4);
        end
      end
      imem_req_ready = (c == 0);
      imem_rsp_valid = (c == 1);
      imem_rsp_data  = memfn(BASE);
      inst_ready     = (c == 8);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_wait();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c >= 2) begin
        checks++;
        if (inst_valid !== 1'b0) begin
          errors++;
          $display("FAIL rw_iv c=%0d: got %b want 0", c, inst_valid);
        end
      end
      if (c == 4) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
          errors++;
          $display("FAIL rw_addr: got v=%b a=%h want 1 80000100",
                   imem_req_valid, imem_req_addr);
        end
      end
      imem_req_ready = (c == 0);
      redirect_valid = (c == 1);
      redirect_pc    = 32'h8000_0103;
      imem_rsp_valid = (c == 3);
      imem_rsp_data  = memfn(BASE);
      inst_ready     = 1'b1;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_hold();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        checks++;
        if (inst_valid !== 1'b1) begin
          errors++;
          $display("FAIL rh_pre: got iv=%b want 1", inst_valid);
        end
      end
      if (c == 3) begin
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 ||
            imem_req_addr !== 32'h8000_1000) begin
          errors++;
          $display("FAIL rh_post: got iv=%b rv=%b a=%h want 0 1 80001000",
                   inst_valid, imem_req_valid, imem_req_addr);
        end
      end
      imem_req_ready = (c == 0);
      imem_rsp_valid = (c == 1);
      imem_rsp_data  = memfn(BASE);
      inst_ready     = 1'b1;
      redirect_valid = (c == 2);
      redirect_pc    = 32'h8000_1000;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      imem_req_ready = (c == 0 || c == 3);
      imem_rsp_valid = (c == 1);
      imem_rsp_data  = memfn(BASE);
      inst_ready     = (c == 2);
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if (imem_req_valid !== 1'b0 || inst !== memfn(BASE)) begin
      errors++;
      $display("FAIL ar_pre: got rv=%b i=%h want 0 %h",
               imem_req_valid, inst, memfn(BASE));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== BASE ||
        inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL ar_now: got rv=%b a=%h iv=%b i=%h pc=%h want 1 %h 0 0 0",
               imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, BASE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = memfn(BASE + 32'h4);
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== BASE || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_restart: got rv=%b a=%h iv=%b want 1 %h 0",
               imem_req_valid, imem_req_addr, inst_valid, BASE);
    end
    idle_inputs();
  endtask

  // Model: the architectural fetch PC advances by 4 on each handshake to
  // decode and jumps on redirect; every request and every delivered word
  // must refer to it, and delivered words must match memory contents.
  task automatic test_random();
    logic [31:0] mpc;
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    int          idle;
    int          delivered;
    logic        prev_hold;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    logic        prev_redir;
    do_reset();
    mpc        = BASE;
    pend       = 1'b0;
    paddr      = 32'h0;
    cnt        = 0;
    idle       = 0;
    delivered  = 0;
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
    prev_inst  = 32'h0;
    prev_pc    = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (imem_req_valid && imem_req_addr !== mpc) begin
        errors++;
        $display("FAIL rnd_addr c=%0d: got %h want %h", c, imem_req_addr, mpc);
      end
      checks++;
      if (imem_req_valid && inst_valid) begin
        errors++;
        $display("FAIL rnd_both c=%0d: got req=1 iv=1 want not both", c);
      end
      if (inst_valid) begin
        checks++;
        if (inst_pc !== mpc || inst !== memfn(mpc)) begin
          errors++;
          $display("FAIL rnd_inst c=%0d: got pc=%h i=%h want pc=%h i=%h",
                   c, inst_pc, inst, mpc, memfn(mpc));
        end
      end
      if (prev_redir) begin
        checks++;
        if (inst_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_squash c=%0d: got iv=%b want 0", c, inst_valid);
        end
      end
      if (prev_hold) begin
        checks++;
        if (inst_valid !== 1'b1 || inst !== prev_inst || inst_pc !== prev_pc) begin
          errors++;
          $display("FAIL rnd_stable c=%0d: got iv=%b i=%h pc=%h want 1 %h %h",
                   c, inst_valid, inst, inst_pc, prev_inst, prev_pc);
        end
      end
      idle = (imem_req_valid || inst_valid) ? 0 : idle + 1;
      checks++;
      if (idle > 8) begin
        errors++;
        $display("FAIL rnd_stall c=%0d: got %0d idle cycles want <=8", c, idle);
        break;
      end

      imem_req_ready = ($urandom_range(2) != 0);
      inst_ready     = $urandom_range(1) == 1;
      redirect_valid = ($urandom_range(9) == 0);
      if ($urandom_range(3) == 0)
        redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else
        redirect_pc = $urandom;
      imem_rsp_valid = pend && (cnt == 0);
      imem_rsp_data  = memfn(paddr);

      prev_hold  = inst_valid && !inst_ready && !redirect_valid;
      prev_inst  = inst;
      prev_pc    = inst_pc;
      prev_redir = redirect_valid;
      if (inst_valid && inst_ready && !redirect_valid) delivered++;
      if (redirect_valid) mpc = redirect_pc & 32'hFFFF_FFFC;
      else if (inst_valid && inst_ready) mpc = mpc + 32'h4;
      if (imem_rsp_valid) pend = 1'b0;
      else if (pend) cnt--;
      if (imem_req_valid && imem_req_ready) begin
        pend  = 1'b1;
        paddr = imem_req_addr;
        cnt   = $urandom_range(3);
      end
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL rnd_progress: got %0d delivered want >=100", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_slow_mem();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
